// File: rtl/sipo_dram.sv
`default_nettype none
// ============================================================================
// Module   : sipo_dram
// Purpose  : Packs groups of WORDS serial words into one parallel word and
//            writes each completed word into the DRAM-bound write FIFO.
// Revision : 1.0
// ============================================================================
module sipo_dram #(
    parameter int INPUT_SIZE  = 8,
    parameter int OUTPUT_SIZE = 288,
    parameter int DROP_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ce,
    input  logic [INPUT_SIZE-1:0]  i_serial,
    input  logic                   i_valid,
    input  logic                   i_sof,
    input  logic                   fifo_full,
    output logic                   fifo_we,
    output logic [OUTPUT_SIZE-1:0] o_parallel,
    output logic                   overflow,
    output logic [DROP_W-1:0]      drop_count,
    output logic                   resync
);

    localparam int WORDS = OUTPUT_SIZE / INPUT_SIZE;
    localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CW-1:0]     c_LAST     = CW'(WORDS - 1);
    localparam logic [DROP_W-1:0] c_DROP_MAX = '1;

    logic [CW-1:0]          r_count;
    logic [OUTPUT_SIZE-1:0] r_asm;
    logic [OUTPUT_SIZE-1:0] r_parallel;
    logic                   r_we;
    logic                   r_resync;
    logic                   r_overflow;
    logic [DROP_W-1:0]      r_drop;

    logic                   w_accept;
    logic                   w_sof;
    logic                   w_complete;
    logic [OUTPUT_SIZE-1:0] w_word;

    assign w_accept   = ce & i_valid;
    assign w_sof      = w_accept & i_sof;
    // A start-of-frame on the last slot discards the word instead of completing it
    assign w_complete = w_accept & ~i_sof & (r_count == c_LAST);
    assign w_word     = {i_serial, r_asm[OUTPUT_SIZE-INPUT_SIZE-1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= '0;
            r_asm      <= '0;
            r_parallel <= '0;
            r_we       <= 1'b0;
            r_resync   <= 1'b0;
            r_overflow <= 1'b0;
            r_drop     <= '0;
        end else if (ce) begin
            r_we     <= w_complete & ~fifo_full;
            r_resync <= w_sof & (r_count != '0);
            if (w_sof) begin
                r_asm   <= {{(OUTPUT_SIZE-INPUT_SIZE){1'b0}}, i_serial};
                r_count <= CW'(1);
            end else if (w_accept) begin
                r_asm[r_count*INPUT_SIZE +: INPUT_SIZE] <= i_serial;
                r_count <= (r_count == c_LAST) ? '0 : r_count + 1'b1;
            end
            if (w_complete) begin
                if (fifo_full) begin
                    r_overflow <= 1'b1;
                    if (r_drop != c_DROP_MAX)
                        r_drop <= r_drop + 1'b1;
                end else begin
                    r_parallel <= w_word;
                end
            end
        end
    end

    // Strobes are held while ce is low so a pending write surfaces once ce returns
    assign fifo_we    = r_we & ce;
    assign resync     = r_resync & ce;
    assign o_parallel = r_parallel;
    assign overflow   = r_overflow;
    assign drop_count = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_sipo_dram.sv
`default_nettype none
// ============================================================================
// Module   : tb_sipo_dram
// Purpose  : Self-checking bench for sipo_dram against a queue-based model.
// Revision : 1.0
// ============================================================================
module tb_sipo_dram;

    logic         clk = 1'b0;
    logic         rst, ce, i_valid, i_sof, fifo_full;
    logic [7:0]   i_serial;
    logic         fifo_we, overflow, resync;
    logic [287:0] o_parallel;
    logic [15:0]  drop_count;

    int checks = 0;
    int errors = 0;

    // Reference model: bytes of the word in progress, plus expected outputs
    logic [7:0]   m_q[$];
    logic [287:0] m_par;
    bit           m_pend, m_rs, m_ov;
    int           m_drops;

    logic         obs_we, obs_rs, exp_we, exp_rs;
    logic [287:0] obs_par, exp_par;

    always #5 clk = ~clk;

    sipo_dram #(.INPUT_SIZE(8), .OUTPUT_SIZE(288), .DROP_W(16)) dut (
        .clk(clk), .rst(rst), .ce(ce), .i_serial(i_serial), .i_valid(i_valid),
        .i_sof(i_sof), .fifo_full(fifo_full), .fifo_we(fifo_we),
        .o_parallel(o_parallel), .overflow(overflow), .drop_count(drop_count),
        .resync(resync)
    );

    // Drive one cycle, sample this cycle's outputs, then advance the model
    task automatic step(input bit r, input bit c, input bit v, input bit s,
                        input logic [7:0] d, input bit f);
        rst = r; ce = c; i_valid = v; i_sof = s; i_serial = d; fifo_full = f;
        #1;
        obs_we  = fifo_we;
        obs_rs  = resync;
        obs_par = o_parallel;
        exp_we  = m_pend && c;
        exp_rs  = m_rs && c;
        exp_par = m_par;
        @(posedge clk);
        if (r) begin
            m_q.delete(); m_par = '0; m_pend = 0; m_rs = 0; m_ov = 0; m_drops = 0;
        end else if (c) begin
            m_pend = 0;
            m_rs   = 0;
            if (v) begin
                if (s) begin
                    if (m_q.size() != 0) m_rs = 1;
                    m_q.delete();
                end
                m_q.push_back(d);
                if (m_q.size() == 36) begin
                    if (f) begin
                        m_ov = 1;
                        if (m_drops < 65535) m_drops++;
                    end else begin
                        for (int i = 0; i < 36; i++) m_par[i*8 +: 8] = m_q[i];
                        m_pend = 1;
                    end
                    m_q.delete();
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        step(1, 1, 0, 0, 8'h00, 0);
        step(1, 1, 0, 0, 8'h00, 0);
        checks++;
        if (o_parallel !== '0 || fifo_we !== 1'b0 || overflow !== 1'b0 ||
            drop_count !== 16'd0 || resync !== 1'b0) begin
            errors++;
            $display("FAIL reset: par=%h we=%b ov=%b drops=%0d rs=%b, required all zero",
                     o_parallel, fifo_we, overflow, drop_count, resync);
        end
    endtask

    task automatic test_contiguous();
        int nw = 0;
        logic [287:0] w[2];
        int cyc[2];
        for (int k = 0; k < 73; k++) begin
            step(0, 1, k < 72, 0, 8'(k), 0);
            checks++;
            if (obs_we !== exp_we) begin
                errors++; $display("FAIL contig_we k=%0d got=%b exp=%b", k, obs_we, exp_we);
            end
            if (obs_we === 1'b1 && nw < 2) begin w[nw] = obs_par; cyc[nw] = k + 1; nw++; end
        end
        checks++;
        if (nw != 2 || cyc[0] != 37 || cyc[1] != 73) begin
            errors++; $display("FAIL contig_count writes=%0d c0=%0d c1=%0d exp 2 at 37,73", nw, cyc[0], cyc[1]);
        end else begin
            checks++;
            if (w[0][7:0] !== 8'h00 || w[0][287:280] !== 8'h23 ||
                w[1][7:0] !== 8'h24 || w[1][287:280] !== 8'h47) begin
                errors++; $display("FAIL contig_pack got %h/%h %h/%h exp 00/23 24/47",
                                   w[0][7:0], w[0][287:280], w[1][7:0], w[1][287:280]);
            end
        end
    endtask

    task automatic test_gapped();
        int nw = 0, wk = -1;
        for (int k = 0; k < 72; k++) begin
            step(0, 1, (k % 2) == 0, 0, 8'(k / 2), 0);
            checks++;
            if (obs_we !== exp_we) begin
                errors++; $display("FAIL gap_we k=%0d got=%b exp=%b", k, obs_we, exp_we);
            end
            if (obs_we === 1'b1) begin
                nw++; wk = k;
                checks++;
                if (obs_par !== exp_par || obs_par[7:0] !== 8'h00 || obs_par[287:280] !== 8'h23) begin
                    errors++; $display("FAIL gap_par got=%h exp=%h", obs_par, exp_par);
                end
            end
        end
        checks++;
        if (nw != 1 || wk != 71) begin
            errors++; $display("FAIL gap_count writes=%0d at=%0d exp 1 at 71", nw, wk);
        end
    endtask

    task automatic test_fifo_full();
        int nw = 0;
        step(1, 1, 0, 0, 8'h00, 0);
        for (int k = 0; k < 37; k++) begin
            step(0, 1, k < 36, 0, 8'($urandom), k == 35);
            if (obs_we === 1'b1) nw++;
        end
        checks++;
        if (nw != 0 || overflow !== 1'b1 || drop_count !== 16'd1 || o_parallel !== '0) begin
            errors++; $display("FAIL full_drop writes=%0d ov=%b drops=%0d par=%h exp 0/1/1/0",
                               nw, overflow, drop_count, o_parallel);
        end
        for (int k = 0; k < 37; k++) begin
            step(0, 1, k < 36, 0, 8'($urandom), 0);
            checks++;
            if (obs_we !== exp_we || (obs_we === 1'b1 && obs_par !== exp_par)) begin
                errors++; $display("FAIL full_after k=%0d we=%b/%b par=%h exp=%h",
                                   k, obs_we, exp_we, obs_par, exp_par);
            end
        end
    endtask

    task automatic test_resync();
        int nw = 0, nr = 0;
        step(1, 1, 0, 0, 8'h00, 0);
        for (int k = 0; k < 47; k++) begin
            step(0, 1, k < 46, k == 10, (k == 10) ? 8'hAA : 8'(k + 1), 0);
            if (obs_rs === 1'b1) nr++;
            if (obs_we === 1'b1) begin
                nw++;
                checks++;
                if (obs_par !== exp_par || obs_par[7:0] !== 8'hAA) begin
                    errors++; $display("FAIL resync_par got=%h exp=%h", obs_par, exp_par);
                end
            end
        end
        checks++;
        if (nr != 1 || nw != 1) begin
            errors++; $display("FAIL resync_a pulses=%0d writes=%0d exp 1/1", nr, nw);
        end
        nw = 0; nr = 0;
        for (int k = 0; k < 37; k++) begin
            step(0, 1, k < 36, k == 35, 8'($urandom), 0);
            if (obs_rs === 1'b1) nr++;
            if (obs_we === 1'b1) nw++;
        end
        checks++;
        if (nr != 1 || nw != 0) begin
            errors++; $display("FAIL resync_last pulses=%0d writes=%0d exp 1/0", nr, nw);
        end
    endtask

    task automatic test_reset_mid();
        int nw = 0;
        for (int k = 0; k < 20; k++) step(0, 1, 1, 0, 8'hF0, 0);
        step(1, 1, 0, 0, 8'h00, 0);
        for (int k = 0; k < 37; k++) begin
            step(0, 1, k < 36, 0, 8'(k + 3), 0);
            if (obs_we === 1'b1) begin
                nw++;
                checks++;
                if (obs_par !== exp_par || obs_par[7:0] !== 8'h03 || obs_par[287:280] !== 8'h26) begin
                    errors++; $display("FAIL rstmid_par got=%h exp=%h", obs_par, exp_par);
                end
            end
        end
        checks++;
        if (nw != 1 || overflow !== 1'b0 || drop_count !== 16'd0) begin
            errors++; $display("FAIL rstmid writes=%0d ov=%b drops=%0d exp 1/0/0", nw, overflow, drop_count);
        end
    endtask

    task automatic test_ce_gating();
        int nw = 0, wk = -1;
        for (int k = 0; k < 40; k++) begin
            step(0, !(k >= 36 && k <= 38), k < 39, 0, 8'($urandom), 0);
            checks++;
            if (obs_we !== exp_we) begin
                errors++; $display("FAIL ce_we k=%0d got=%b exp=%b", k, obs_we, exp_we);
            end
            if (obs_we === 1'b1) begin nw++; wk = k; end
        end
        checks++;
        if (nw != 1 || wk != 39) begin
            errors++; $display("FAIL ce_count writes=%0d at=%0d exp 1 at 39", nw, wk);
        end
        // Words offered while ce was low must not have advanced the slot counter
        for (int k = 0; k < 37; k++) begin
            step(0, 1, k < 36, 0, 8'($urandom), 0);
            checks++;
            if (obs_we !== exp_we || (obs_we === 1'b1 && obs_par !== exp_par)) begin
                errors++; $display("FAIL ce_after k=%0d we=%b/%b par=%h exp=%h",
                                   k, obs_we, exp_we, obs_par, exp_par);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0,
                 8'($urandom), $urandom_range(0, 4) == 0);
            checks++;
            if (obs_we !== exp_we || obs_rs !== exp_rs || obs_par !== exp_par ||
                overflow !== m_ov || drop_count !== 16'(m_drops)) begin
                errors++;
                $display("FAIL rand k=%0d we=%b/%b rs=%b/%b ov=%b/%b drops=%0d/%0d par=%h exp=%h",
                         k, obs_we, exp_we, obs_rs, exp_rs, overflow, m_ov,
                         drop_count, m_drops, obs_par, exp_par);
            end
        end
    endtask

    initial begin
        rst = 1'b1; ce = 1'b0; i_valid = 1'b0; i_sof = 1'b0; i_serial = '0; fifo_full = 1'b0;
        m_par = '0; m_pend = 0; m_rs = 0; m_ov = 0; m_drops = 0;
        test_reset();
        test_contiguous();
        test_gapped();
        test_fifo_full();
        test_resync();
        test_reset_mid();
        test_ce_gating();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sipo_dram.md
Name: sipo_dram

Overview:
- Inverse of the DRAM read-side serializer: collects a stream of 8-bit words and packs each group of 36 into one 288-bit word.
- Each packed word is written into the DRAM-bound write FIFO with a single-cycle write strobe.
- Sits between the 8-bit detection datapath and the write FIFO feeding the DRAM controller.
- Slot order matches the serializer: first byte of a word lands in bits [7:0], last byte in bits [287:280].

Parameters:
- INPUT_SIZE, 8, width of each serial input word.
- OUTPUT_SIZE, 288, width of the packed parallel word. Must be an integer multiple of INPUT_SIZE.
- WORDS (localparam), OUTPUT_SIZE/INPUT_SIZE = 36, serial words per parallel word.
- DROP_W, 16, width of the dropped-word counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- ce  in  1  clock enable. When low, all state holds and fifo_we is forced 0.
- i_serial  in  INPUT_SIZE  serial data word.
- i_valid  in  1  i_serial is valid this cycle.
- i_sof  in  1  start-of-frame. Qualified by i_valid; forces this word into slot 0.
- fifo_full  in  1  write FIFO full flag.
- fifo_we  out  1  write strobe to FIFO, one cycle per packed word.
- o_parallel  out  OUTPUT_SIZE  packed word, FIFO write data.
- overflow  out  1  sticky: at least one packed word was dropped because the FIFO was full.
- drop_count  out  DROP_W  number of dropped words; saturates at all-ones.
- resync  out  1  one-cycle pulse: i_sof discarded a partial word.

Behaviour:
- Reset values: counter=0, shift/assembly register=0, o_parallel=0, fifo_we=0, overflow=0, drop_count=0, resync=0. Reset mid-word discards the partial word silently; resync is not pulsed.
- Slot counter range 0..WORDS-1. Accepted word means ce & i_valid.
- On an accepted word, i_serial is written to slot `counter`, i.e. bits [(counter+1)*INPUT_SIZE-1 : counter*INPUT_SIZE] of the assembly register.
  - If counter==WORDS-1: the word is complete; counter wraps to 0.
  - Otherwise counter increments.
- Cycles with i_valid=0 leave counter and assembly unchanged. Gaps of any length between words are legal.
- Completion, using fifo_full sampled in the same cycle as the 36th accepted word:
  - fifo_full=0: on the next edge, o_parallel is loaded with the complete word (including the final byte) and fifo_we=1 for exactly one cycle. Latency: fifo_we is high in the cycle after the 36th word is sampled.
  - fifo_full=1: no write. overflow is set and drop_count increments (saturating). o_parallel keeps its previous value.
- o_parallel changes only on successful writes; it holds between writes.
- The assembly register is separate from o_parallel, so back-to-back streaming at one word per cycle is sustained with no stall. fifo_we may then pulse every 36 cycles.
- i_sof (with i_valid & ce):
  - The word goes into slot 0 and counter becomes 1.
  - If counter was non-zero, the partial word is discarded and resync pulses one cycle later.
  - i_sof with counter==0 is normal; no resync.
  - i_sof arriving exactly when counter==WORDS-1: sof wins. The 35 buffered words are discarded, no write occurs, and resync pulses.
- ce=0: counter, assembly, o_parallel, overflow and drop_count hold; fifo_we=0; resync=0. A pending write from the previous cycle's completion is not lost: if ce drops in the cycle fifo_we would assert, fifo_we asserts on the first cycle ce is high again.
- overflow and drop_count clear only on rst.

Test Plan:
- Contiguous stream: 72 words with values 0x00..0x47, fifo_full=0 -> fifo_we pulses at cycle 37 and cycle 73; first o_parallel[7:0]=0x00 and [287:280]=0x23; second o_parallel[7:0]=0x24 and [287:280]=0x47.
- Gapped input: 36 words with i_valid toggling every other cycle -> exactly one fifo_we, the cycle after the 36th valid word, with the same packing as the contiguous case.
- FIFO full: fifo_full=1 during the 36th word of the first packed word -> no fifo_we, overflow=1, drop_count=1, o_parallel stays 0. The next 36 words with fifo_full=0 are written normally.
- Resync: 10 words, then i_sof with value 0xAA followed by 35 words -> resync pulses once; written word has [7:0]=0xAA; the 10 earlier words are absent. Repeat with i_sof on the 36th word -> no write, resync=1.
- Reset mid-word: 20 words, rst for 1 cycle, then 36 words -> one write containing only the post-reset words; overflow=0 and drop_count=0.
- ce gating: drop ce in the cycle after the 36th word for 3 cycles -> fifo_we asserts once, on the first cycle ce is back high; no state change while ce=0.
